// File: rtl/tpu_pkg.sv
// Shared sizing and state encoding for the TPU operand feeder.
package tpu_pkg;
  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int IDXW  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } feed_state_e;
endpackage

// File: rtl/tpu_skew_line.sv
// Fixed-depth data+valid delay line; data is forced to zero whenever valid is low.
module tpu_skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0][W-1:0] data_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      // masking at entry keeps every downstream stage zero while invalid
      vld_pipe[0]  <= in_vld;
      data_pipe[0] <= in_vld ? in_data : '0;
      for (int j = 1; j < DEPTH; j++) begin
        vld_pipe[j]  <= vld_pipe[j-1];
        data_pipe[j] <= data_pipe[j-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH-1];
  assign out_data = data_pipe[DEPTH-1];
endmodule

// File: rtl/tpu_operand_feeder.sv
// Fetches one tile of A/B operand words and feeds them diagonally skewed into the systolic array.
module tpu_operand_feeder #(
  parameter int LANES = tpu_pkg::LANES,
  parameter int DW    = tpu_pkg::DW,
  parameter int IDXW  = tpu_pkg::IDXW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            k_len,
  input  logic [IDXW-1:0]       a_base,
  input  logic [IDXW-1:0]       b_base,
  output logic                  busy,
  output logic                  done,
  output logic                  A_wr_en,
  output logic [IDXW-1:0]       A_index,
  input  logic [LANES*DW-1:0]   A_data_out,
  output logic                  B_wr_en,
  output logic [IDXW-1:0]       B_index,
  input  logic [LANES*DW-1:0]   B_data_out,
  output logic [LANES*DW-1:0]   arr_a,
  output logic [LANES*DW-1:0]   arr_b,
  output logic [LANES-1:0]      arr_a_vld,
  output logic [LANES-1:0]      arr_b_vld,
  output logic                  arr_clr
);
  import tpu_pkg::*;

  localparam int DCW = $clog2(LANES + 1);

  feed_state_e    state, state_nx;
  logic [7:0]     k_last, kcnt;
  logic [DCW-1:0] dcnt;
  logic           rd_vld;

  assign A_wr_en = 1'b0;
  assign B_wr_en = 1'b0;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start && k_len != 8'd0) state_nx = ST_FETCH;
      ST_FETCH: if (kcnt == k_last) state_nx = ST_DRAIN;
      // lane LANES-1 of the last element leaves LANES+1 cycles after fetch ends
      ST_DRAIN: if (dcnt == DCW'(LANES)) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_last  <= '0;
      kcnt    <= '0;
      dcnt    <= '0;
      rd_vld  <= 1'b0;
      done    <= 1'b0;
      arr_clr <= 1'b0;
      A_index <= '0;
      B_index <= '0;
    end else begin
      done    <= 1'b0;
      arr_clr <= 1'b0;
      rd_vld  <= (state == ST_FETCH);
      case (state)
        ST_IDLE: if (start) begin
          if (k_len == 8'd0) begin
            done <= 1'b1;
          end else begin
            arr_clr <= 1'b1;
            k_last  <= k_len - 8'd1;
            kcnt    <= '0;
            A_index <= a_base;
            B_index <= b_base;
          end
        end
        ST_FETCH: begin
          kcnt <= kcnt + 8'd1;
          dcnt <= '0;
          if (kcnt != k_last) begin
            A_index <= A_index + IDXW'(1);
            B_index <= B_index + IDXW'(1);
          end
        end
        ST_DRAIN: begin
          dcnt <= dcnt + DCW'(1);
          if (dcnt == DCW'(LANES)) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // read data lands one cycle after its index; lane i then waits i+1 more cycles
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tpu_skew_line #(.DEPTH(i + 1), .W(DW)) u_skew_a (
      .clk(clk), .rst(rst), .in_vld(rd_vld), .in_data(A_data_out[i*DW +: DW]),
      .out_vld(arr_a_vld[i]), .out_data(arr_a[i*DW +: DW])
    );
    tpu_skew_line #(.DEPTH(i + 1), .W(DW)) u_skew_b (
      .clk(clk), .rst(rst), .in_vld(rd_vld), .in_data(B_data_out[i*DW +: DW]),
      .out_vld(arr_b_vld[i]), .out_data(arr_b[i*DW +: DW])
    );
  end
endmodule

// File: tb/tb_tpu_operand_feeder.sv
// Directed and randomized checks of the operand feeder's fetch, skew, handshake and reset behaviour.
module tb_tpu_operand_feeder;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  k_len;
  logic [15:0] a_base, b_base;
  logic        busy, done, A_wr_en, B_wr_en, arr_clr;
  logic [15:0] A_index, B_index;
  logic [31:0] A_data_out, B_data_out, arr_a, arr_b;
  logic [3:0]  arr_a_vld, arr_b_vld;

  logic [31:0] amem [0:65535];
  logic [31:0] bmem [0:65535];
  int checks = 0, failures = 0;

  tpu_operand_feeder dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .a_base(a_base), .b_base(b_base),
    .busy(busy), .done(done), .A_wr_en(A_wr_en), .A_index(A_index), .A_data_out(A_data_out),
    .B_wr_en(B_wr_en), .B_index(B_index), .B_data_out(B_data_out), .arr_a(arr_a), .arr_b(arr_b),
    .arr_a_vld(arr_a_vld), .arr_b_vld(arr_b_vld), .arr_clr(arr_clr)
  );

  always #5 clk = ~clk;

  // one-cycle read latency buffers
  always @(posedge clk) begin
    A_data_out <= amem[A_index];
    B_data_out <= bmem[B_index];
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; k_len = '0; a_base = '0; b_base = '0;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (arr_clr !== 1'b0) begin failures++; $display("FAIL reset_clr got=%b exp=0", arr_clr); end
    checks++; if ({arr_a_vld, arr_b_vld} !== 8'h00) begin failures++; $display("FAIL reset_vld got=%h exp=00", {arr_a_vld, arr_b_vld}); end
    checks++; if ({arr_a, arr_b} !== 64'h0) begin failures++; $display("FAIL reset_arr got=%h exp=0", {arr_a, arr_b}); end
    checks++; if ({A_index, B_index} !== 32'h0) begin failures++; $display("FAIL reset_index got=%h exp=0", {A_index, B_index}); end
    checks++; if ({A_wr_en, B_wr_en} !== 2'b00) begin failures++; $display("FAIL reset_wr_en got=%b exp=00", {A_wr_en, B_wr_en}); end
    rst = 1'b0;
    step();
  endtask

  // K=4: A word k = 0x04030201 + k*0x04040404, so lane i of element k is (i+1)+4k
  task automatic test_basic();
    logic [3:0]  ev;
    logic [31:0] ea, eb, w;
    logic [15:0] ei;
    int k;
    start = 1'b1; k_len = 8'd4; a_base = 16'h0010; b_base = 16'h0200;
    for (int t = 1; t <= 11; t++) begin
      step();
      if (t == 1) begin start = 1'b0; k_len = 8'd9; a_base = 16'h7777; end
      ei = (t <= 4) ? 16'h0010 + 16'(t - 1) : 16'h0013;
      ev = '0; ea = '0; eb = '0;
      for (int i = 0; i < 4; i++) begin
        k = t - 3 - i;
        if (k >= 0 && k < 4) begin
          ev[i] = 1'b1;
          ea[i*8 +: 8] = 8'(i + 1 + 4 * k);
          w = bmem[16'h0200 + 16'(k)];
          eb[i*8 +: 8] = w[i*8 +: 8];
        end
      end
      checks++; if (A_index !== ei) begin failures++; $display("FAIL basic_a_index t=%0d got=%h exp=%h", t, A_index, ei); end
      checks++; if (B_index !== ei + 16'h01F0) begin failures++; $display("FAIL basic_b_index t=%0d got=%h exp=%h", t, B_index, ei + 16'h01F0); end
      checks++; if (busy !== (t <= 9)) begin failures++; $display("FAIL basic_busy t=%0d got=%b exp=%b", t, busy, t <= 9); end
      checks++; if (done !== (t == 10)) begin failures++; $display("FAIL basic_done t=%0d got=%b exp=%b", t, done, t == 10); end
      checks++; if (arr_clr !== (t == 1)) begin failures++; $display("FAIL basic_clr t=%0d got=%b exp=%b", t, arr_clr, t == 1); end
      checks++; if ({arr_a_vld, arr_b_vld} !== {ev, ev}) begin failures++; $display("FAIL basic_vld t=%0d got=%b/%b exp=%b", t, arr_a_vld, arr_b_vld, ev); end
      checks++; if (arr_a !== ea) begin failures++; $display("FAIL basic_arr_a t=%0d got=%h exp=%h", t, arr_a, ea); end
      checks++; if (arr_b !== eb) begin failures++; $display("FAIL basic_arr_b t=%0d got=%h exp=%h", t, arr_b, eb); end
    end
  endtask

  task automatic test_zero_k();
    start = 1'b1; k_len = 8'd0; a_base = 16'h1234; b_base = 16'h4321;
    for (int t = 1; t <= 4; t++) begin
      step();
      start = 1'b0;
      checks++; if (A_index !== 16'h0013) begin failures++; $display("FAIL zero_index t=%0d got=%h exp=0013", t, A_index); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy t=%0d got=%b exp=0", t, busy); end
      checks++; if (done !== (t == 1)) begin failures++; $display("FAIL zero_done t=%0d got=%b exp=%b", t, done, t == 1); end
      checks++; if ({arr_clr, arr_a_vld, arr_b_vld} !== 9'h0) begin failures++; $display("FAIL zero_clr_vld t=%0d got=%h exp=0", t, {arr_clr, arr_a_vld, arr_b_vld}); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] w0, w1;
    w0 = amem[16'hFFFF]; w1 = amem[16'h0000];
    start = 1'b1; k_len = 8'd1; a_base = 16'hFFFF; b_base = 16'h0005;
    for (int t = 1; t <= 7; t++) begin
      step();
      start = 1'b0;
      if (t == 1) begin checks++; if (A_index !== 16'hFFFF) begin failures++; $display("FAIL wrap1_index got=%h exp=ffff", A_index); end end
      if (t == 3) begin checks++; if (arr_a[7:0] !== w0[7:0]) begin failures++; $display("FAIL wrap1_lane0 got=%h exp=%h", arr_a[7:0], w0[7:0]); end end
      checks++; if (done !== (t == 7)) begin failures++; $display("FAIL wrap1_done t=%0d got=%b exp=%b", t, done, t == 7); end
    end
    start = 1'b1; k_len = 8'd2; a_base = 16'hFFFF;
    for (int t = 1; t <= 8; t++) begin
      step();
      start = 1'b0;
      if (t == 1) begin checks++; if (A_index !== 16'hFFFF) begin failures++; $display("FAIL wrap2_index0 got=%h exp=ffff", A_index); end end
      if (t == 2) begin checks++; if (A_index !== 16'h0000) begin failures++; $display("FAIL wrap2_index1 got=%h exp=0000", A_index); end end
      if (t == 3) begin checks++; if (arr_a[7:0] !== w0[7:0]) begin failures++; $display("FAIL wrap2_lane0_k0 got=%h exp=%h", arr_a[7:0], w0[7:0]); end end
      if (t == 4) begin checks++; if (arr_a[7:0] !== w1[7:0]) begin failures++; $display("FAIL wrap2_lane0_k1 got=%h exp=%h", arr_a[7:0], w1[7:0]); end end
      checks++; if (done !== (t == 8)) begin failures++; $display("FAIL wrap2_done t=%0d got=%b exp=%b", t, done, t == 8); end
    end
  endtask

  // tile1 K=3 at t=0 (ignored start at t=2), tile2 K=2 started in tile1's done cycle (t=9)
  task automatic test_back_to_back();
    logic [3:0]  ev;
    logic [31:0] ea, eb, w;
    int k1, k2;
    start = 1'b1; k_len = 8'd3; a_base = 16'h0020; b_base = 16'h0300;
    for (int t = 1; t <= 18; t++) begin
      step();
      start = 1'b0;
      if (t == 2) begin start = 1'b1; k_len = 8'd5; a_base = 16'h0080; b_base = 16'h0380; end
      if (t == 9) begin start = 1'b1; k_len = 8'd2; a_base = 16'h0040; b_base = 16'h0340; end
      ev = '0; ea = '0; eb = '0;
      for (int i = 0; i < 4; i++) begin
        k1 = t - 3 - i; k2 = t - 12 - i;
        if (k1 >= 0 && k1 < 3) begin
          ev[i] = 1'b1;
          w = amem[16'h0020 + 16'(k1)]; ea[i*8 +: 8] = w[i*8 +: 8];
          w = bmem[16'h0300 + 16'(k1)]; eb[i*8 +: 8] = w[i*8 +: 8];
        end
        if (k2 >= 0 && k2 < 2) begin
          ev[i] = 1'b1;
          w = amem[16'h0040 + 16'(k2)]; ea[i*8 +: 8] = w[i*8 +: 8];
          w = bmem[16'h0340 + 16'(k2)]; eb[i*8 +: 8] = w[i*8 +: 8];
        end
      end
      checks++; if (arr_clr !== (t == 1 || t == 10)) begin failures++; $display("FAIL b2b_clr t=%0d got=%b exp=%b", t, arr_clr, t == 1 || t == 10); end
      checks++; if (done !== (t == 9 || t == 17)) begin failures++; $display("FAIL b2b_done t=%0d got=%b exp=%b", t, done, t == 9 || t == 17); end
      checks++; if (busy !== ((t >= 1 && t <= 8) || (t >= 10 && t <= 16))) begin failures++; $display("FAIL b2b_busy t=%0d got=%b", t, busy); end
      checks++; if ({arr_a_vld, arr_b_vld} !== {ev, ev}) begin failures++; $display("FAIL b2b_vld t=%0d got=%b/%b exp=%b", t, arr_a_vld, arr_b_vld, ev); end
      checks++; if ({arr_a, arr_b} !== {ea, eb}) begin failures++; $display("FAIL b2b_data t=%0d got=%h/%h exp=%h/%h", t, arr_a, arr_b, ea, eb); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    start = 1'b1; k_len = 8'd8; a_base = 16'h0100; b_base = 16'h0500;
    for (int t = 1; t <= 5; t++) begin
      step();
      start = 1'b0;
      if (t == 4) rst = 1'b1;
    end
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if ({arr_a_vld, arr_b_vld} !== 8'h00) begin failures++; $display("FAIL rstmid_vld got=%h exp=00", {arr_a_vld, arr_b_vld}); end
    checks++; if ({arr_a, arr_b} !== 64'h0) begin failures++; $display("FAIL rstmid_arr got=%h exp=0", {arr_a, arr_b}); end
    for (int t = 0; t < 14; t++) begin
      step();
      checks++; if ({done, busy, arr_a_vld} !== 6'h0) begin failures++; $display("FAIL rstmid_quiet t=%0d got=%h exp=0", t, {done, busy, arr_a_vld}); end
    end
    w = amem[16'h0010];
    start = 1'b1; k_len = 8'd1; a_base = 16'h0010; b_base = 16'h0200;
    for (int t = 1; t <= 7; t++) begin
      step();
      start = 1'b0;
      if (t == 1) begin checks++; if (arr_clr !== 1'b1) begin failures++; $display("FAIL rstmid_fresh_clr got=%b exp=1", arr_clr); end end
      if (t == 3) begin checks++; if ({arr_a_vld, arr_a[7:0]} !== {4'b0001, w[7:0]}) begin failures++; $display("FAIL rstmid_fresh_lane0 got=%h exp=%h", {arr_a_vld, arr_a[7:0]}, {4'b0001, w[7:0]}); end end
      checks++; if (done !== (t == 7)) begin failures++; $display("FAIL rstmid_fresh_done t=%0d got=%b exp=%b", t, done, t == 7); end
    end
  endtask

  // random K and data; each tile's start is issued in the previous tile's done cycle
  task automatic test_random();
    logic [3:0]  ev;
    logic [31:0] ea, eb, w;
    logic [15:0] ab, bb;
    int kk, k;
    for (int j = 0; j < 65536; j++) begin amem[j] = $urandom; bmem[j] = $urandom; end
    kk = $urandom_range(1, 255); ab = 16'($urandom); bb = 16'($urandom);
    start = 1'b1; k_len = 8'(kk); a_base = ab; b_base = bb;
    for (int n = 0; n < 6; n++) begin
      for (int t = 1; t <= kk + 6; t++) begin
        step();
        start = 1'b0; k_len = 8'($urandom); a_base = 16'($urandom);
        ev = '0; ea = '0; eb = '0;
        for (int i = 0; i < 4; i++) begin
          k = t - 3 - i;
          if (k >= 0 && k < kk) begin
            ev[i] = 1'b1;
            w = amem[ab + 16'(k)]; ea[i*8 +: 8] = w[i*8 +: 8];
            w = bmem[bb + 16'(k)]; eb[i*8 +: 8] = w[i*8 +: 8];
          end
        end
        checks++; if ({arr_a_vld, arr_b_vld} !== {ev, ev}) begin failures++; $display("FAIL rnd_vld n=%0d K=%0d t=%0d got=%b/%b exp=%b", n, kk, t, arr_a_vld, arr_b_vld, ev); end
        checks++; if ({arr_a, arr_b} !== {ea, eb}) begin failures++; $display("FAIL rnd_data n=%0d K=%0d t=%0d got=%h/%h exp=%h/%h", n, kk, t, arr_a, arr_b, ea, eb); end
        checks++; if ({done, busy} !== ((t == kk + 6) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rnd_done_busy n=%0d K=%0d t=%0d got=%b", n, kk, t, {done, busy}); end
      end
      if (n < 5) begin
        kk = $urandom_range(1, 255); ab = 16'($urandom); bb = 16'($urandom);
        start = 1'b1; k_len = 8'(kk); a_base = ab; b_base = bb;
      end
    end
  endtask

  initial begin
    A_data_out = '0; B_data_out = '0;
    for (int j = 0; j < 65536; j++) begin
      amem[j] = 32'h04030201 + 32'(j - 16) * 32'h04040404;
      bmem[j] = {8'(j) ^ 8'hA5, 8'(j >> 8), 8'(j), 8'h5A};
    end
    test_reset();
    test_basic();
    test_zero_k();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
